// File: rtl/pulse_sequencer.sv
// Slt/En pulse-stream generator for the dual-channel event counter.
// Optional `define PSEQ_ABORT_EN adds an Abort input that ends a command early.
module pulse_sequencer #(
    parameter int CNT_W = 16,
    parameter int DIV1  = 4,
    parameter int GAP   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Chan,
    input  logic [CNT_W-1:0] Count,
`ifdef PSEQ_ABORT_EN
    input  logic             Abort,
`endif
    output logic             Slt,
    output logic             En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Sent
);

    localparam int RW = CNT_W + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [RW-1:0]    DIV1_W   = RW'(DIV1);
    localparam logic [RW-1:0]    REM_ONE  = RW'(1);
    localparam logic [CNT_W-1:0] SENT_ONE = CNT_W'(1);
    localparam logic [2:0]       SUB_LAST = 3'(DIV1 - 1);
    localparam logic [3:0]       GAP_LD   = 4'((GAP == 0) ? 0 : GAP - 1);

    logic [1:0]    state;
    logic          chan_q;
    logic [RW-1:0] remaining;
    logic [3:0]    gapcnt;
    logic [2:0]    subcnt;
    logic          abort_req;
    logic [RW-1:0] total;

`ifdef PSEQ_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    assign total = Chan ? ({3'b000, Count} * DIV1_W) : {3'b000, Count};

    // Outputs are pure decodes of state registers, so they change only on Clk edges.
    assign En   = (state == S_PULSE);
    assign Busy = (state != S_IDLE);
    assign Done = (state == S_DONE);
    assign Slt  = (state != S_IDLE) ? chan_q : 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            chan_q    <= 1'b0;
            remaining <= '0;
            gapcnt    <= '0;
            subcnt    <= '0;
            Sent      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        chan_q    <= Chan;
                        Sent      <= '0;
                        subcnt    <= '0;
                        remaining <= total;
                        state     <= (Count != '0) ? S_PULSE : S_DONE;
                    end
                end
                S_PULSE: begin
                    remaining <= remaining - REM_ONE;
                    if (!chan_q) begin
                        Sent <= Sent + SENT_ONE;
                    end else if (subcnt == SUB_LAST) begin
                        subcnt <= '0;
                        Sent   <= Sent + SENT_ONE;
                    end else begin
                        subcnt <= subcnt + 3'd1;
                    end
                    // The pulse in this cycle is already on En, so an abort still credits it.
                    if (remaining == REM_ONE || abort_req) begin
                        state <= S_DONE;
                    end else if (GAP != 0) begin
                        state  <= S_GAP;
                        gapcnt <= GAP_LD;
                    end
                end
                S_GAP: begin
                    if (abort_req) begin
                        state <= S_DONE;
                    end else if (gapcnt == '0) begin
                        state <= S_PULSE;
                    end else begin
                        gapcnt <= gapcnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed and scoreboard checks for pulse_sequencer (GAP=1 and GAP=0 instances).
`timescale 1ns/1ps
module tb_pulse_sequencer;

    localparam int CNT_W = 16;
    localparam int DIV1  = 4;

    logic             Clk;
    logic             Reset;
    logic             Start, Chan;
    logic [CNT_W-1:0] Count;
    logic             Abort;
    logic             slt, en, busy, done;
    logic [CNT_W-1:0] sent;

    logic             start0, chan0;
    logic [CNT_W-1:0] count0;
    logic             abort0;
    logic             slt0, en0, busy0, done0;
    logic [CNT_W-1:0] sent0;

    int n_checks = 0;
    int n_fail   = 0;

    int out0 = 0, out1 = 0, pre1 = 0;

    pulse_sequencer #(.CNT_W(CNT_W), .DIV1(DIV1), .GAP(1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Chan(Chan), .Count(Count),
`ifdef PSEQ_ABORT_EN
        .Abort(Abort),
`endif
        .Slt(slt), .En(en), .Busy(busy), .Done(done), .Sent(sent)
    );

    pulse_sequencer #(.CNT_W(CNT_W), .DIV1(DIV1), .GAP(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(start0), .Chan(chan0), .Count(count0),
`ifdef PSEQ_ABORT_EN
        .Abort(abort0),
`endif
        .Slt(slt0), .En(en0), .Busy(busy0), .Done(done0), .Sent(sent0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Event-counter model fed by the GAP=1 instance.
    always @(negedge Clk) begin
        if (Reset) begin
            pre1 = 0;
        end else if (en) begin
            if (!slt) begin
                out0 = out0 + 1;
            end else begin
                pre1 = pre1 + 1;
                if (pre1 == DIV1) begin
                    pre1 = 0;
                    out1 = out1 + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_cmd(input logic ch, input int cnt, output int pulses);
        bit finished;
        pulses   = 0;
        finished = 0;
        Start = 1'b1; Chan = ch; Count = CNT_W'(cnt);
        tick;
        Start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (en) pulses++;
            if (done) begin
                finished = 1;
                break;
            end
            tick;
        end
        if (!finished) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int pulses;
        int b0, b1;
        logic ch;
        int cnt;
        bit seen;

        Reset = 1'b1; Start = 1'b0; Chan = 1'b0; Count = '0; Abort = 1'b0;
        start0 = 1'b0; chan0 = 1'b0; count0 = '0; abort0 = 1'b0;
        tick; tick;
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_slt", {31'd0, slt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sent", {16'd0, sent}, 32'd0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        Reset = 1'b0;
        tick;

        // GAP=1, ch0, Count=3: En 1,0,1,0,1 then Done
        Start = 1'b1; Chan = 1'b0; Count = 16'd3;
        tick;
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("g1_en", {31'd0, en}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("g1_slt", {31'd0, slt}, 32'd0);
            check("g1_busy", {31'd0, busy}, 32'd1);
            tick;
        end
        check("g1_done", {31'd0, done}, 32'd1);
        check("g1_done_en", {31'd0, en}, 32'd0);
        check("g1_sent", {16'd0, sent}, 32'd3);
        tick;
        check("g1_idle_busy", {31'd0, busy}, 32'd0);
        check("g1_idle_done", {31'd0, done}, 32'd0);
        check("g1_sent_hold", {16'd0, sent}, 32'd3);

        // GAP=0, ch1, Count=2: 8 back-to-back pulses with Slt=1
        start0 = 1'b1; chan0 = 1'b1; count0 = 16'd2;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("g0_en", {31'd0, en0}, 32'd1);
            check("g0_slt", {31'd0, slt0}, 32'd1);
            check("g0_sent", {16'd0, sent0}, (i < 4) ? 32'd0 : 32'd1);
            tick;
        end
        check("g0_done", {31'd0, done0}, 32'd1);
        check("g0_done_en", {31'd0, en0}, 32'd0);
        check("g0_done_slt", {31'd0, slt0}, 32'd1);
        check("g0_sent_fin", {16'd0, sent0}, 32'd2);
        tick;
        check("g0_idle_slt", {31'd0, slt0}, 32'd0);
        check("g0_idle_busy", {31'd0, busy0}, 32'd0);

        // Count=0: Done in the cycle after Start, no En
        Start = 1'b1; Chan = 1'b1; Count = 16'd0;
        tick;
        Start = 1'b0;
        check("z_done", {31'd0, done}, 32'd1);
        check("z_en", {31'd0, en}, 32'd0);
        check("z_busy", {31'd0, busy}, 32'd1);
        check("z_sent", {16'd0, sent}, 32'd0);
        tick;
        check("z_idle", {31'd0, busy}, 32'd0);

        // Start re-pulsed while busy is ignored
        Start = 1'b1; Chan = 1'b0; Count = 16'd3;
        tick;
        Count = 16'd9; Chan = 1'b1;
        pulses = 0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 2) Start = 1'b0;
            if (en) pulses++;
            if (done) begin
                seen = 1;
                break;
            end
            tick;
        end
        Start = 1'b0;
        check("busy_start_done", {31'd0, seen}, 32'd1);
        check("busy_start_pulses", pulses, 32'd3);
        check("busy_start_sent", {16'd0, sent}, 32'd3);
        tick;

        // Reset mid-command after 7 pulses of ch1 Count=5
        Start = 1'b1; Chan = 1'b1; Count = 16'd5;
        tick;
        Start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            if (en) pulses++;
            if (pulses == 7) break;
            tick;
        end
        check("rm_pulses", pulses, 32'd7);
        check("rm_sent_pre", {16'd0, sent}, 32'd1);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check("rm_en", {31'd0, en}, 32'd0);
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_sent", {16'd0, sent}, 32'd0);
        check("rm_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("rm_quiet", {30'd0, en, done}, 32'd0);
        end

`ifdef PSEQ_ABORT_EN
        // Abort after pulse 6 of ch1 Count=3
        Start = 1'b1; Chan = 1'b1; Count = 16'd3;
        tick;
        Start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            if (en) pulses++;
            if (pulses == 6) break;
            tick;
        end
        check("ab_pulses", pulses, 32'd6);
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        check("ab_done", {31'd0, done}, 32'd1);
        check("ab_en", {31'd0, en}, 32'd0);
        check("ab_sent", {16'd0, sent}, 32'd1);
        tick;
        check("ab_idle", {30'd0, busy, en}, 32'd0);
        // Re-sync the counter model prescaler after the partial unit.
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        tick;
`endif

        // Scoreboard against the event-counter model
        for (int n = 0; n < 200; n++) begin
            ch  = 1'($urandom_range(0, 1));
            cnt = int'($urandom_range(0, 6));
            b0  = out0;
            b1  = out1;
            run_cmd(ch, cnt, pulses);
            tick;
            check("sb_out0", out0 - b0, ch ? 32'd0 : cnt);
            check("sb_out1", out1 - b1, ch ? cnt : 32'd0);
            check("sb_pulses", pulses, ch ? cnt * DIV1 : cnt);
            check("sb_sent", {16'd0, sent}, cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
